cake_order_ctrl: RTL and testbench

//  Game-level sequencer for recipe generation and cake stacking.
//  - Drives recipe_render: holds ld_recipe until done_recipe, then latches the 18-bit recipe.
//  - Checks each caught layer colour against the expected recipe layer, in order.
//  - Runs a per-order countdown, keeps score and misses, and declares game over.

---
 rtl/cake_pkg.sv | 30 +++
 rtl/cake_order_ctrl_timer.sv | 25 ++
 rtl/cake_order_ctrl.sv | 138 +++++++++++++
 tb/tb_cake_order_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cake_pkg.sv
// Shared types and helpers for the cake order sequencer: state encoding,
// colour constants and recipe field extraction.
package cake_pkg;
  localparam int LAYER_W  = 3;
  localparam int RECIPE_W = 18;
  localparam logic [LAYER_W-1:0] CLR_CHERRY = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STACK = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  // Layers are stored MSB-first after the cherry; the cherry sits on top at index 5.
  function automatic logic [LAYER_W-1:0] layer_field(input logic [RECIPE_W-1:0] rec,
                                                     input logic [2:0] idx);
    case (idx)
      3'd0:    layer_field = rec[14:12];
      3'd1:    layer_field = rec[11:9];
      3'd2:    layer_field = rec[8:6];
      3'd3:    layer_field = rec[5:3];
      3'd4:    layer_field = rec[2:0];
      3'd5:    layer_field = rec[17:15];
      default: layer_field = '0;
    endcase
  endfunction
endpackage

// File: rtl/cake_order_ctrl_timer.sv
// Per-order countdown: loads the full budget, decrements on tick, holds at zero.
module order_timer #(
  parameter int TICKS = 30,
  parameter int W     = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_tick,
  input  logic         i_clear,
  output logic [W-1:0] o_time_left,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      r_cnt <= '0;
    else if (i_clear)               r_cnt <= '0;
    else if (i_load)                r_cnt <= W'(TICKS);
    else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_time_left = r_cnt;
  assign o_zero      = (r_cnt == '0);
endmodule

// File: rtl/cake_order_ctrl.sv
// Game sequencer: requests recipes, checks caught layers in order, runs the
// order timer and keeps score/misses until the game is over.
module cake_order_ctrl
  import cake_pkg::*;
#(
  parameter int NUM_LAYERS  = 5,
  parameter int CLR_W       = 3,
  parameter int ORDER_TICKS = 30,
  parameter int MAX_MISSES  = 3,
  parameter int SCORE_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                tick,
  output logic                ld_recipe,
  input  logic                done_recipe,
  input  logic [RECIPE_W-1:0] recipe,
  input  logic                catch_valid,
  input  logic [CLR_W-1:0]    catch_clr,
  output logic                catch_ready,
  output logic [CLR_W-1:0]    target_clr,
  output logic [2:0]          layer_idx,
  output logic                order_ok,
  output logic                order_fail,
  output logic [SCORE_W-1:0]  score,
  output logic [1:0]          misses,
  output logic [4:0]          time_left,
  output logic                game_over
);
  localparam logic [2:0] CHERRY_IDX = 3'(NUM_LAYERS);

  state_t                r_state;
  logic [RECIPE_W-1:0]   r_recipe;
  logic [2:0]            r_idx;
  logic [CLR_W-1:0]      r_tgt;
  logic                  r_ld, r_rdy, r_ok, r_fail, r_over;
  logic [SCORE_W-1:0]    r_score;
  logic [1:0]            r_misses;

  logic w_load, w_tick, w_clear, w_zero, w_hit;
  logic [4:0] w_time_left;

  assign w_load  = (r_state == S_LOAD) && done_recipe;
  assign w_tick  = (r_state == S_STACK) && tick;
  assign w_clear = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;
  assign w_hit   = (catch_clr == r_tgt);

  order_timer #(.TICKS(ORDER_TICKS), .W(5)) u_timer (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_load      (w_load),
    .i_tick      (w_tick),
    .i_clear     (w_clear),
    .o_time_left (w_time_left),
    .o_zero      (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_recipe <= '0;
      r_idx    <= '0;
      r_tgt    <= '0;
      r_ld     <= 1'b0;
      r_rdy    <= 1'b0;
      r_ok     <= 1'b0;
      r_fail   <= 1'b0;
      r_over   <= 1'b0;
      r_score  <= '0;
      r_misses <= '0;
    end else begin
      r_ok   <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: if (start) begin
          r_state  <= S_LOAD;
          r_ld     <= 1'b1;
          r_over   <= 1'b0;
          r_score  <= '0;
          r_misses <= '0;
        end
        S_LOAD: if (done_recipe) begin
          r_recipe <= recipe;
          r_idx    <= '0;
          r_tgt    <= CLR_W'(layer_field(recipe, 3'd0));
          r_ld     <= 1'b0;
          r_rdy    <= 1'b1;
          r_state  <= S_STACK;
        end
        S_STACK: begin
          // A correct cherry beats a same-cycle timeout; any other catch does not.
          if (catch_valid && w_hit && r_idx == CHERRY_IDX) begin
            r_state <= S_DONE;
            r_rdy   <= 1'b0;
            r_tgt   <= '0;
            r_ok    <= 1'b1;
          end else if ((catch_valid && !w_hit) || w_zero) begin
            r_state <= S_FAIL;
            r_rdy   <= 1'b0;
            r_tgt   <= '0;
            r_fail  <= 1'b1;
          end else if (catch_valid) begin
            r_idx <= r_idx + 3'd1;
            r_tgt <= CLR_W'(layer_field(r_recipe, r_idx + 3'd1));
          end
        end
        S_DONE: begin
          if (r_score != '1) r_score <= r_score + 1'b1;
          r_state <= S_LOAD;
          r_ld    <= 1'b1;
        end
        S_FAIL: begin
          r_misses <= r_misses + 2'd1;
          if (r_misses == 2'(MAX_MISSES - 1)) begin
            r_state <= S_OVER;
            r_over  <= 1'b1;
          end else begin
            r_state <= S_LOAD;
            r_ld    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ld_recipe   = r_ld;
  assign catch_ready = r_rdy;
  assign target_clr  = r_tgt;
  assign layer_idx   = r_idx;
  assign order_ok    = r_ok;
  assign order_fail  = r_fail;
  assign score       = r_score;
  assign misses      = r_misses;
  assign time_left   = w_time_left;
  assign game_over   = r_over;
endmodule

// File: tb/tb_cake_order_ctrl.sv
// Bench for cake_order_ctrl: directed game scenarios plus random play, all
// checked every cycle against a behavioural game model.
module tb_cake_order_ctrl;
  import cake_pkg::*;

  logic        clk = 0, reset = 1, start = 0, tick = 0, done_recipe = 0, catch_valid = 0;
  logic [17:0] recipe = '0;
  logic [2:0]  catch_clr = '0;
  logic        ld_recipe, catch_ready, order_ok, order_fail, game_over;
  logic [2:0]  target_clr, layer_idx;
  logic [7:0]  score;
  logic [1:0]  misses;
  logic [4:0]  time_left;

  int checks = 0, failures = 0;

  cake_order_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .ld_recipe(ld_recipe),
    .done_recipe(done_recipe), .recipe(recipe), .catch_valid(catch_valid),
    .catch_clr(catch_clr), .catch_ready(catch_ready), .target_clr(target_clr),
    .layer_idx(layer_idx), .order_ok(order_ok), .order_fail(order_fail), .score(score),
    .misses(misses), .time_left(time_left), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Behavioural game model: phase of the game plus the counters a player sees.
  typedef enum {M_IDLE, M_LOAD, M_STACK, M_DONE, M_FAIL, M_OVER} mph_t;
  mph_t m_ph = M_IDLE;
  int m_score = 0, m_misses = 0, m_time = 0, m_idx = 0;
  int m_lay [6] = '{0, 0, 0, 0, 0, 0};

  always @(posedge clk or posedge reset) begin
    int nt;
    if (reset) begin
      m_ph = M_IDLE; m_score = 0; m_misses = 0; m_time = 0; m_idx = 0;
      for (int i = 0; i < 6; i++) m_lay[i] = 0;
    end else begin
      case (m_ph)
        M_IDLE, M_OVER: if (start) begin m_ph = M_LOAD; m_score = 0; m_misses = 0; m_time = 0; end
        M_LOAD: if (done_recipe) begin
          for (int i = 0; i < 5; i++) m_lay[i] = int'((recipe >> (3 * (4 - i))) & 18'd7);
          m_lay[5] = int'(recipe >> 15);
          m_idx = 0; m_time = 30; m_ph = M_STACK;
        end
        M_STACK: begin
          nt = (tick && m_time > 0) ? m_time - 1 : m_time;
          if (catch_valid && int'(catch_clr) == m_lay[m_idx] && m_idx == 5) m_ph = M_DONE;
          else if (catch_valid && int'(catch_clr) != m_lay[m_idx])         m_ph = M_FAIL;
          else if (m_time == 0)                                             m_ph = M_FAIL;
          else if (catch_valid)                                             m_idx++;
          m_time = nt;
        end
        M_DONE: begin m_score = (m_score == 255) ? 255 : m_score + 1; m_ph = M_LOAD; end
        M_FAIL: begin m_misses++; m_ph = (m_misses == 3) ? M_OVER : M_LOAD; end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ld_recipe",   32'(ld_recipe),   32'(m_ph == M_LOAD));
    chk("catch_ready", 32'(catch_ready), 32'(m_ph == M_STACK));
    chk("target_clr",  32'(target_clr),  (m_ph == M_STACK) ? m_lay[m_idx] : 0);
    chk("order_ok",    32'(order_ok),    32'(m_ph == M_DONE));
    chk("order_fail",  32'(order_fail),  32'(m_ph == M_FAIL));
    chk("game_over",   32'(game_over),   32'(m_ph == M_OVER));
    chk("score",       32'(score),       m_score);
    chk("misses",      32'(misses),      m_misses);
    if (m_ph == M_STACK) begin
      chk("layer_idx", 32'(layer_idx), m_idx);
      chk("time_left", 32'(time_left), m_time);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ld();
    int n = 0;
    while (!ld_recipe && n < 20) begin step(); n++; end
    chk("wait_ld", 32'(ld_recipe), 1);
  endtask

  task automatic load_order(input logic [17:0] rec);
    wait_ld();
    recipe = rec; done_recipe = 1; step(); done_recipe = 0;
  endtask

  task automatic do_catch(input int c);
    catch_valid = 1; catch_clr = 3'(c); step(); catch_valid = 0;
  endtask

  function automatic logic [17:0] rand_recipe();
    logic [17:0] r;
    r = 18'($urandom);
    r[17:15] = CLR_CHERRY;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ld_cnt;
    repeat (2) step();
    reset = 0;
    chk("rst_ld", 32'(ld_recipe), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_time", 32'(time_left), 0);

    // Recipe request handshake: ld_recipe held across the wait and the done cycle.
    recipe = 18'o712345;
    start = 1; step(); start = 0;
    ld_cnt = 0;
    repeat (6) begin if (ld_recipe) ld_cnt++; step(); end
    done_recipe = 1; if (ld_recipe) ld_cnt++; step(); done_recipe = 0;
    chk("t1_ld_cycles", ld_cnt, 7);
    chk("t1_ld_drop", 32'(ld_recipe), 0);
    chk("t1_target", 32'(target_clr), 1);
    chk("t1_time", 32'(time_left), 30);

    // Full correct order.
    for (int i = 0; i < 6; i++) begin
      chk("t2_idx", 32'(layer_idx), i);
      do_catch((i == 5) ? 7 : i + 1);
    end
    chk("t2_ok", 32'(order_ok), 1);
    step();
    chk("t2_score", 32'(score), 1);
    chk("t2_ld", 32'(ld_recipe), 1);

    // Wrong colour on the second layer.
    load_order(18'o712345);
    do_catch(1);
    chk("t3_target", 32'(target_clr), 2);
    do_catch(6);
    chk("t3_fail", 32'(order_fail), 1);
    step();
    chk("t3_misses", 32'(misses), 1);
    chk("t3_score", 32'(score), 1);

    // Timeout, then a third miss ends the game.
    load_order(18'o712345);
    repeat (30) begin tick = 1; step(); tick = 0; end
    chk("t4_time0", 32'(time_left), 0);
    chk("t4_still_stack", 32'(catch_ready), 1);
    step();
    chk("t4_fail", 32'(order_fail), 1);
    step();
    load_order(18'o712345);
    do_catch(0);
    step();
    chk("t4_over", 32'(game_over), 1);
    chk("t4_ready", 32'(catch_ready), 0);
    chk("t4_misses", 32'(misses), 3);
    tick = 1; catch_valid = 1; done_recipe = 1; step(); step();
    tick = 0; catch_valid = 0; done_recipe = 0;

    // Cherry on the last tick, and cherry while the timer already reads zero.
    start = 1; step(); start = 0;
    chk("t5_score_clr", 32'(score), 0);
    load_order(rand_recipe());
    for (int i = 0; i < 5; i++) do_catch(m_lay[i]);
    repeat (29) begin tick = 1; step(); end
    tick = 1; do_catch(m_lay[5]); tick = 0;
    chk("t5_ok", 32'(order_ok), 1);
    chk("t5_nofail", 32'(order_fail), 0);
    load_order(rand_recipe());
    for (int i = 0; i < 5; i++) do_catch(m_lay[i]);
    repeat (30) begin tick = 1; step(); end
    tick = 0;
    chk("t5b_time0", 32'(time_left), 0);
    do_catch(m_lay[5]);
    chk("t5b_ok", 32'(order_ok), 1);

    // Asynchronous reset in the middle of stacking.
    load_order(rand_recipe());
    do_catch(m_lay[0]);
    reset = 1; #1;
    chk("t6_ready", 32'(catch_ready), 0);
    chk("t6_idx", 32'(layer_idx), 0);
    chk("t6_score", 32'(score), 0);
    chk("t6_time", 32'(time_left), 0);
    chk("t6_target", 32'(target_clr), 0);
    step(); reset = 0;
    start = 1; step(); start = 0;
    chk("t6_restart", 32'(ld_recipe), 1);

    // Score saturation.
    for (int n = 0; n < 256; n++) begin
      load_order(rand_recipe());
      for (int i = 0; i < 6; i++) do_catch(m_lay[i]);
      step();
    end
    chk("sat_score", 32'(score), 255);

    // Random play.
    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 39) == 0);
      tick        = ($urandom_range(0, 3) == 0);
      done_recipe = ($urandom_range(0, 2) == 0);
      catch_valid = ($urandom_range(0, 2) == 0);
      recipe      = rand_recipe();
      catch_clr   = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
                    ((m_ph == M_STACK) ? 3'(m_lay[m_idx]) : 3'($urandom));
      reset       = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 0; start = 0; tick = 0; done_recipe = 0; catch_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
